stage2_fmap_streamer: RTL and testbench
=======================================

# stage2_fmap_streamer

Ping-pong frame buffer and raster transmitter feeding the stage-2 convolution core. It captures a complete CH×ROW×COL feature map from the stage-1 output stream and narrows each sample from IN_BW to OUT_BW bits. It then replays the frame to stage 2 as a raster pixel stream: one pixel per valid cycle, all channels in parallel, channel 0 in the LSBs. With two banks, stage 1 can write frame n+1 while frame n is being streamed.

## Interface
Parameters:
- CH, 3, channels per pixel
- COL, 12, pixels per row
- ROW, 12, rows per frame
- IN_BW, 32, signed input sample width
- OUT_BW, 20, signed output sample width (matches stage-2 input width)

Ports:
- clk  in  1  single clock; all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- i_in_valid  in  1  input pixel strobe
- i_in_fmap  in  CH*IN_BW  input pixel; channel k at [k*IN_BW +: IN_BW]
- o_in_ready  out  1  write bank available; reset 1
- i_ot_en  in  1  downstream enable; when low, streaming pauses
- o_ot_valid  out  1  output pixel strobe; reset 0
- o_ot_fmap  out  CH*OUT_BW  output pixel; channel k at [k*OUT_BW +: OUT_BW]; reset 0
- o_frame_done  out  1  one-cycle pulse, coincident with the last pixel of a frame; reset 0
- o_err  out  1  sticky; set when i_in_valid arrives while o_in_ready=0; cleared only by reset; reset 0

## Operation
- Storage: two banks of ROW*COL words, each CH*OUT_BW wide. Each bank has a full flag. Reset clears both flags, wr_bank=0, rd_bank=0 and all pointers.
- Write side:
  - A pixel is accepted when i_in_valid && o_in_ready. It is narrowed and stored at wr_ptr in wr_bank, and wr_ptr increments.
  - At wr_ptr==ROW*COL-1: wr_ptr wraps to 0, full[wr_bank] is set and wr_bank toggles.
  - o_in_ready = !full[wr_bank].
  - i_in_valid with o_in_ready=0 is discarded and sets o_err.
- Narrowing (per channel sample): see Configuration.
- Read FSM, two states:
  - IDLE: if full[rd_bank], go to STREAM with rd_ptr=0.
  - STREAM: in each cycle with i_ot_en=1, issue a read at rd_ptr and increment it. When i_ot_en=0, no read is issued and rd_ptr holds.
  - On issuing rd_ptr==ROW*COL-1: clear full[rd_bank] and toggle rd_bank.
  - If the new rd_bank is already full, remain in STREAM with rd_ptr=0 (back-to-back frames, no bubble). Otherwise go to IDLE.
- Output register:
  - o_ot_valid is the registered read-issue strobe.
  - o_ot_fmap is the read data. It holds its value when o_ot_valid=0.
  - o_frame_done is the registered "last address issued" flag.
- Simultaneous events:
  - The write side completing into bank A and the read side releasing bank B in the same cycle are independent; both flag updates take effect.
  - A write into the bank whose full flag is being cleared that cycle is not possible, because the write side only targets a non-full bank.
- Reset mid-operation: all flags, pointers and state return to reset values immediately. Partial frames are lost. Bank contents need not be cleared.

## Timing
- Cycle N: final pixel of a frame is accepted. N+1: full flag is visible, FSM enters STREAM. N+2: first read is issued (i_ot_en=1). N+3: o_ot_valid=1 with pixel 0.
- Read latency: 1 cycle from read issue to o_ot_valid.
- Throughput: one pixel per cycle while i_ot_en=1. A frame takes ROW*COL cycles of enable.
- With both banks full, o_in_ready drops in the cycle after the accepting edge. It rises in the cycle after the read side issues the last address of the older bank.

## Configuration
- ST2_STREAM_SAT_EN defined: each sample saturates to [-2^(OUT_BW-1), 2^(OUT_BW-1)-1]. Values already in range pass unchanged.
- ST2_STREAM_SAT_EN undefined: each sample is truncated to its low OUT_BW bits (two's-complement wrap).

## Test plan
- Single frame, i_ot_en=1: write 144 pixels with channel k of pixel p = 4p+k → 144 consecutive o_ot_valid cycles starting 3 cycles after the last write. Output is raster order, pixel p channel k = 4p+k. o_frame_done is high only on p=143.
- Three back-to-back frames written continuously with i_ot_en=0 → o_in_ready falls after the 288th pixel and the 289th write sets o_err=1. Raising i_ot_en then emits frames 1 and 2 with no gap between them.
- i_ot_en toggled 1,0 repeatedly during streaming → exactly 144 valid pixels, in order, with none duplicated or skipped. o_ot_fmap holds its value during gaps.
- Narrowing with input sample 0x0008_0000 → 0x7FFFF when ST2_STREAM_SAT_EN is defined, 0x80000 when undefined. Input 0xFFF8_0000 → 0x80000 in both builds.
- reset_n pulsed low at pixel 70 of streaming → all outputs 0, o_in_ready=1, o_err=0. A new full frame afterward streams correctly from pixel 0.
- Write frame 2 while frame 1 streams (write rate 1 pixel/2 cycles) → frame 1 output is uncorrupted. Frame 2 starts 3 cycles after its last write (or 1 cycle after frame 1's last pixel if later), with no o_err.

Source files
------------

// File: rtl/stage2_fmap_streamer_if.sv
// Pixel-stream bundle between stage 1, the stage-2 fmap streamer and stage 2.
// The master drives the input stream and enable; the slave is the streamer.
interface stage2_fmap_streamer_if #(
  parameter int CH     = 3,
  parameter int IN_BW  = 32,
  parameter int OUT_BW = 20
);
  logic                 i_in_valid;
  logic [CH*IN_BW-1:0]  i_in_fmap;
  logic                 o_in_ready;
  logic                 i_ot_en;
  logic                 o_ot_valid;
  logic [CH*OUT_BW-1:0] o_ot_fmap;
  logic                 o_frame_done;
  logic                 o_err;

  modport master (
    output i_in_valid, i_in_fmap, i_ot_en,
    input  o_in_ready, o_ot_valid, o_ot_fmap, o_frame_done, o_err
  );

  modport slave (
    input  i_in_valid, i_in_fmap, i_ot_en,
    output o_in_ready, o_ot_valid, o_ot_fmap, o_frame_done, o_err
  );
endinterface

// File: rtl/stage2_fmap_streamer.sv
// Ping-pong CHxROWxCOL frame buffer: captures and narrows stage-1 pixels, replays them in raster order.
// Define ST2_STREAM_SAT_EN to saturate samples when narrowing; otherwise they are truncated.
module stage2_fmap_streamer #(
  parameter int CH     = 3,
  parameter int COL    = 12,
  parameter int ROW    = 12,
  parameter int IN_BW  = 32,
  parameter int OUT_BW = 20
) (
  input logic               clk,
  input logic               reset_n,
  stage2_fmap_streamer_if.slave bus
);
  localparam int DEPTH = ROW * COL;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int PIX_W = CH * OUT_BW;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  typedef enum logic {ST_IDLE, ST_STREAM} rd_state_e;

`ifdef ST2_STREAM_SAT_EN
  localparam logic signed [IN_BW-1:0] SAT_MAX = {{(IN_BW-OUT_BW+1){1'b0}}, {(OUT_BW-1){1'b1}}};
  localparam logic signed [IN_BW-1:0] SAT_MIN = ~SAT_MAX;

  function automatic logic [OUT_BW-1:0] narrow(input logic signed [IN_BW-1:0] x);
    if (x > SAT_MAX)      return SAT_MAX[OUT_BW-1:0];
    else if (x < SAT_MIN) return SAT_MIN[OUT_BW-1:0];
    else                  return x[OUT_BW-1:0];
  endfunction
`else
  function automatic logic [OUT_BW-1:0] narrow(input logic signed [IN_BW-1:0] x);
    logic unused_hi;
    unused_hi = ^x[IN_BW-1:OUT_BW];
    return x[OUT_BW-1:0];
  endfunction
`endif

  logic [PIX_W-1:0] mem [2][DEPTH];

  rd_state_e        state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [1:0]       full_q, full_d;
  logic             err_q, err_d;
  logic             ot_valid_q, ot_valid_d;
  logic [PIX_W-1:0] ot_fmap_q, ot_fmap_d;
  logic             frame_done_q, frame_done_d;

  logic             in_ready, wr_fire, wr_last, rd_issue, rd_last;
  logic [PIX_W-1:0] wr_pix;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    in_ready = !full_q[wr_bank_q];
    wr_fire  = bus.i_in_valid && in_ready;
    wr_last  = wr_fire && (wr_ptr_q == LAST_PTR);
    rd_issue = (state_q == ST_STREAM) && bus.i_ot_en;
    rd_last  = rd_issue && (rd_ptr_q == LAST_PTR);

    wr_pix = '0;
    for (int k = 0; k < CH; k++) begin
      wr_pix[k*OUT_BW +: OUT_BW] = narrow(bus.i_in_fmap[k*IN_BW +: IN_BW]);
    end

    wr_ptr_d  = wr_ptr_q;
    wr_bank_d = wr_bank_q;
    full_d    = full_q;
    err_d     = err_q | (bus.i_in_valid & ~in_ready);

    if (wr_fire) begin
      wr_ptr_d = wr_last ? '0 : wr_ptr_q + 1'b1;
      if (wr_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
    // Writes only target a non-full bank, so this never collides with the set above.
    if (rd_last) full_d[rd_bank_q] = 1'b0;

    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    rd_bank_d = rd_bank_q;
    unique case (state_q)
      ST_IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d  = ST_STREAM;
          rd_ptr_d = '0;
        end
      end
      ST_STREAM: begin
        if (rd_last) begin
          rd_bank_d = ~rd_bank_q;
          rd_ptr_d  = '0;
          state_d   = full_d[~rd_bank_q] ? ST_STREAM : ST_IDLE;
        end else if (rd_issue) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ot_valid_d   = rd_issue;
    ot_fmap_d    = rd_issue ? mem[rd_bank_q][rd_ptr_q] : ot_fmap_q;
    frame_done_d = rd_last;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      full_q       <= '0;
      err_q        <= 1'b0;
      ot_valid_q   <= 1'b0;
      ot_fmap_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      full_q       <= full_d;
      err_q        <= err_d;
      ot_valid_q   <= ot_valid_d;
      ot_fmap_q    <= ot_fmap_d;
      frame_done_q <= frame_done_d;
    end
  end

  // NOTE: the frame store has no reset; full flags gate every read, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_bank_q][wr_ptr_q] <= wr_pix;
  end

  assign bus.o_in_ready   = in_ready;
  assign bus.o_ot_valid   = ot_valid_q;
  assign bus.o_ot_fmap    = ot_fmap_q;
  assign bus.o_frame_done = frame_done_q;
  assign bus.o_err        = err_q;
endmodule

// File: tb/tb_stage2_fmap_streamer.sv
// Directed bench for stage2_fmap_streamer: a negedge scoreboard checks every output pixel,
// while one initial block walks through the frame-level scenarios.
module tb_stage2_fmap_streamer;
  localparam int N = 144;

  typedef struct packed {
    logic [59:0] pix;
    logic        last;
  } exp_t;

  logic clk;
  logic reset_n;
  int   check_cnt = 0;
  int   err_cnt   = 0;
  int   rx_cnt    = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [59:0] prev_fmap;

`ifdef ST2_STREAM_SAT_EN
  localparam logic [19:0] EXP_POS_OVF = 20'h7FFFF;
`else
  localparam logic [19:0] EXP_POS_OVF = 20'h80000;
`endif

  stage2_fmap_streamer_if #(.CH(3), .IN_BW(32), .OUT_BW(20)) bus ();

  stage2_fmap_streamer #(.CH(3), .COL(12), .ROW(12), .IN_BW(32), .OUT_BW(20)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every valid pixel is matched in order; idle cycles must hold data and keep done low.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_fmap = bus.o_ot_fmap;
    end else begin
      if (bus.o_ot_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("pixel_data", 64'(bus.o_ot_fmap), 64'(mon_e.pix));
          check("frame_done", 64'(bus.o_frame_done), 64'(mon_e.last));
        end
        rx_cnt++;
      end else begin
        check("fmap_hold", 64'(bus.o_ot_fmap), 64'(prev_fmap));
        check("done_idle", 64'(bus.o_frame_done), 64'd0);
      end
      prev_fmap = bus.o_ot_fmap;
    end
  end

  task automatic put_raw(input logic [31:0] c0, c1, c2, input logic [19:0] e0, e1, e2,
                         input bit push, input bit last);
    bus.i_in_valid = 1'b1;
    bus.i_in_fmap  = {c2, c1, c0};
    if (push) exp_q.push_back('{pix: {e2, e1, e0}, last: last});
    @(negedge clk);
    bus.i_in_valid = 1'b0;
  endtask

  // Channel k of pixel p in frame f is (f<<16)+4p+k, always inside the 20-bit signed range.
  task automatic put_seq(input int f, input int p, input bit push);
    logic [31:0] v;
    v = 32'((f << 16) + 4 * p);
    put_raw(v, v + 1, v + 2, v[19:0], v[19:0] + 20'd1, v[19:0] + 20'd2, push, p == N - 1);
  endtask

  task automatic write_frame(input int f, input bit gap, input bit special);
    for (int p = 0; p < N; p++) begin
      if (special && p == 10)
        put_raw(32'h0008_0000, 32'hFFF8_0000, 32'h0007_FFFF,
                EXP_POS_OVF, 20'h80000, 20'h7FFFF, 1'b1, 1'b0);
      else
        put_seq(f, p, 1'b1);
      if (gap) @(negedge clk);
    end
  endtask

  task automatic wait_first_valid(input string tag, input int exp_lat);
    int n = 0;
    while (!bus.o_ot_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(n), 64'(exp_lat));
  endtask

  task automatic expect_run(input string tag, input int len);
    for (int i = 1; i < len; i++) begin
      @(negedge clk);
      check(tag, 64'(bus.o_ot_valid), 64'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(bus.o_ot_valid),   64'd0);
    check({tag, "_fmap"},  64'(bus.o_ot_fmap),    64'd0);
    check({tag, "_done"},  64'(bus.o_frame_done), 64'd0);
    check({tag, "_ready"}, 64'(bus.o_in_ready),   64'd1);
    check({tag, "_err"},   64'(bus.o_err),        64'd0);
  endtask

  initial begin
    int rx0;
    int n;
    reset_n        = 1'b0;
    bus.i_in_valid = 1'b0;
    bus.i_in_fmap  = '0;
    bus.i_ot_en    = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);

    // Single frame, enable high: first pixel 3 cycles after the last write, 144 contiguous.
    bus.i_ot_en = 1'b1;
    write_frame(1, 1'b0, 1'b0);
    wait_first_valid("t1_latency", 2);
    expect_run("t1_contiguous", N);
    @(negedge clk);
    check("t1_end_gap", 64'(bus.o_ot_valid), 64'd0);
    check("t1_ready", 64'(bus.o_in_ready), 64'd1);

    // Enable toggling, with narrowing boundary samples at pixel 10.
    bus.i_ot_en = 1'b0;
    write_frame(2, 1'b0, 1'b1);
    rx0 = rx_cnt;
    n   = 0;
    while (rx_cnt < rx0 + N && n < 1000) begin
      bus.i_ot_en = ~bus.i_ot_en;
      @(negedge clk);
      n++;
    end
    bus.i_ot_en = 1'b0;
    repeat (4) @(negedge clk);
    check("t3_pixel_count", 64'(rx_cnt - rx0), 64'(N));
    check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

    // Frame 4 written at half rate while frame 3 streams.
    bus.i_ot_en = 1'b1;
    write_frame(3, 1'b0, 1'b0);
    rx0 = rx_cnt;
    write_frame(4, 1'b1, 1'b0);
    check("t6_frame3_done", 64'(rx_cnt - rx0), 64'(N));
    wait_first_valid("t6_latency", 1);
    expect_run("t6_contiguous", N);
    repeat (2) @(negedge clk);
    check("t6_err", 64'(bus.o_err), 64'd0);
    check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

    // Both banks filled with streaming held off; the 289th write is rejected.
    bus.i_ot_en = 1'b0;
    for (int f = 5; f <= 6; f++) begin
      for (int p = 0; p < N; p++) begin
        if (f == 6 && p == N - 1) check("t2_ready_before_288", 64'(bus.o_in_ready), 64'd1);
        put_seq(f, p, 1'b1);
      end
    end
    check("t2_ready_after_288", 64'(bus.o_in_ready), 64'd0);
    check("t2_err_before_289", 64'(bus.o_err), 64'd0);
    put_seq(7, 0, 1'b0);
    check("t2_err_after_289", 64'(bus.o_err), 64'd1);
    bus.i_ot_en = 1'b1;
    wait_first_valid("t2_latency", 1);
    expect_run("t2_back_to_back", 2 * N);
    @(negedge clk);
    check("t2_ready_after_drain", 64'(bus.o_in_ready), 64'd1);
    check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of streaming, then a fresh frame.
    write_frame(7, 1'b0, 1'b0);
    rx0 = rx_cnt;
    n   = 0;
    while (rx_cnt < rx0 + 70 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t5_reached_70", 64'(rx_cnt >= rx0 + 70), 64'd1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_outputs("t5_reset");
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    write_frame(0, 1'b0, 1'b0);
    wait_first_valid("t5_latency", 2);
    expect_run("t5_contiguous", N);
    repeat (2) @(negedge clk);
    check("t5_queue_empty", 64'(exp_q.size()), 64'd0);
    check("t5_err", 64'(bus.o_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end
endmodule
